// File: rtl/cnn_dat_issue.sv
// cnn_dat_issue: producer side of the convolution loop-control interface.
// Walks height (innermost), then Win/Tin tiles, then Wout/Tout tiles. For
// each beat it presents a feature-buffer read address on a valid/ready
// handshake. Every Wout tile re-reads the same height*Win_div_Tin words.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   start                 begin a pass (accepted only when idle)
//   height, Win_div_Tin,
//   Wout_div_Tout,
//   base_addr             pass configuration, latched on an accepted start
//   dat_rdy               downstream ready
//   dat_vld, dat_addr,
//   dat_first, dat_last   beat stream (first = h 0 of Win tile 0,
//                         last = final beat of the pass)
//   busy, done            pass in progress / one-cycle completion pulse
//   stall_cycles          count of cycles with dat_vld & !dat_rdy
//
// Optional feature macro: CNN_DAT_ISSUE_STALL_CNT_EN enables stall_cycles.
// If the macro is not defined, stall_cycles is tied to zero.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | issuing beats
// FIN   | done pulse cycle
module cnn_dat_issue #(
  parameter int H_W    = 10,
  parameter int WT_W   = 8,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [H_W-1:0]    height,
  input  logic [WT_W-1:0]   Win_div_Tin,
  input  logic [WT_W-1:0]   Wout_div_Tout,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              dat_rdy,
  output logic              dat_vld,
  output logic [ADDR_W-1:0] dat_addr,
  output logic              dat_first,
  output logic              dat_last,
  output logic              busy,
  output logic              done,
  output logic [31:0]       stall_cycles
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t state, state_nxt;

  logic [H_W-1:0]    height_q, h_cnt, h_d, h_inc;
  logic [WT_W-1:0]   win_q, wout_q, win_cnt, wout_cnt, win_d, wout_d, win_inc, wout_inc;
  logic [ADDR_W-1:0] base_q, addr_d;
  logic              vld_d, first_d, last_d, busy_d, done_d;
  logic              xfer, accept, zero_cfg, h_wrap, win_wrap, tile_wrap;

  assign xfer      = dat_vld & dat_rdy;
  assign accept    = (state == IDLE) & start;
  assign zero_cfg  = (height == '0) | (Win_div_Tin == '0) | (Wout_div_Tout == '0);
  assign h_wrap    = (h_cnt == height_q - H_W'(1));
  assign win_wrap  = (win_cnt == win_q - WT_W'(1));
  assign tile_wrap = h_wrap & win_wrap;

  // Counter values for the beat following the current one
  assign h_inc    = h_wrap ? '0 : h_cnt + H_W'(1);
  assign win_inc  = h_wrap ? (win_wrap ? '0 : win_cnt + WT_W'(1)) : win_cnt;
  assign wout_inc = tile_wrap ? wout_cnt + WT_W'(1) : wout_cnt;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = zero_cfg ? FIN : RUN;
      RUN:     if (xfer && dat_last) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    vld_d   = dat_vld;
    addr_d  = dat_addr;
    first_d = dat_first;
    last_d  = dat_last;
    busy_d  = busy;
    done_d  = 1'b0;
    h_d     = h_cnt;
    win_d   = win_cnt;
    wout_d  = wout_cnt;
    case (state)
      IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          h_d    = '0;
          win_d  = '0;
          wout_d = '0;
          if (zero_cfg) begin
            // Empty pass: no beats, a single FIN cycle with busy and done high
            done_d = 1'b1;
          end else begin
            vld_d   = 1'b1;
            addr_d  = base_addr;
            first_d = 1'b1;
            last_d  = (height == H_W'(1)) && (Win_div_Tin == WT_W'(1)) &&
                      (Wout_div_Tout == WT_W'(1));
          end
        end
      end
      RUN: begin
        if (xfer) begin
          if (dat_last) begin
            vld_d   = 1'b0;
            first_d = 1'b0;
            last_d  = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            h_d     = h_inc;
            win_d   = win_inc;
            wout_d  = wout_inc;
            // New Wout tile restarts the same input window at base
            addr_d  = tile_wrap ? base_q : dat_addr + ADDR_W'(1);
            first_d = tile_wrap;
            last_d  = (h_inc == height_q - H_W'(1)) && (win_inc == win_q - WT_W'(1)) &&
                      (wout_inc == wout_q - WT_W'(1));
          end
        end
      end
      FIN: begin
        vld_d  = 1'b0;
        busy_d = 1'b0;
      end
      default: begin
        vld_d  = 1'b0;
        busy_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dat_vld   <= 1'b0;
      dat_addr  <= '0;
      dat_first <= 1'b0;
      dat_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      h_cnt     <= '0;
      win_cnt   <= '0;
      wout_cnt  <= '0;
      height_q  <= '0;
      win_q     <= '0;
      wout_q    <= '0;
      base_q    <= '0;
    end else begin
      dat_vld   <= vld_d;
      dat_addr  <= addr_d;
      dat_first <= first_d;
      dat_last  <= last_d;
      busy      <= busy_d;
      done      <= done_d;
      h_cnt     <= h_d;
      win_cnt   <= win_d;
      wout_cnt  <= wout_d;
      if (accept) begin
        height_q <= height;
        win_q    <= Win_div_Tin;
        wout_q   <= Wout_div_Tout;
        base_q   <= base_addr;
      end
    end
  end

`ifdef CNN_DAT_ISSUE_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst || accept)
      stall_cycles <= '0;
    else if (dat_vld && !dat_rdy && (stall_cycles != 32'hFFFF_FFFF))
      stall_cycles <= stall_cycles + 32'd1;
  end
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_cnn_dat_issue.sv
module tb_cnn_dat_issue;

  logic        clk = 1'b0;
  logic        rst, start, dat_rdy;
  logic [9:0]  height;
  logic [7:0]  Win_div_Tin, Wout_div_Tout;
  logic [15:0] base_addr;
  logic        dat_vld, dat_first, dat_last, busy, done;
  logic [15:0] dat_addr;
  logic [31:0] stall_cycles;

`ifdef CNN_DAT_ISSUE_STALL_CNT_EN
  localparam int STALL_ON = 1;
`else
  localparam int STALL_ON = 0;
`endif

  cnn_dat_issue dut (
    .clk(clk), .rst(rst), .start(start), .height(height),
    .Win_div_Tin(Win_div_Tin), .Wout_div_Tout(Wout_div_Tout),
    .base_addr(base_addr), .dat_rdy(dat_rdy), .dat_vld(dat_vld),
    .dat_addr(dat_addr), .dat_first(dat_first), .dat_last(dat_last),
    .busy(busy), .done(done), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit chk_en = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Behavioural model: the expected beat list of a pass, consumed on handshakes
  typedef struct {logic [15:0] addr; logic first; logic last;} beat_t;
  beat_t q[$];
  int    m_phase = 0;  // 0 idle, 1 beats outstanding, 2 completion cycle
  bit    m_done = 0, m_fin_busy = 0;
  logic [31:0] m_stalls = 0;

  task automatic build_beats(input int h, input int wi, input int wo, input logic [15:0] b);
    beat_t bt;
    q.delete();
    for (int o = 0; o < wo; o++)
      for (int i = 0; i < wi; i++)
        for (int r = 0; r < h; r++) begin
          bt.addr  = b + 16'(i * h + r);
          bt.first = (r == 0) && (i == 0);
          bt.last  = (o == wo - 1) && (i == wi - 1) && (r == h - 1);
          q.push_back(bt);
        end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      q.delete(); m_phase = 0; m_done = 0; m_fin_busy = 0; m_stalls = 0;
    end else begin
      m_done = 0;
      case (m_phase)
        0: if (start) begin
             m_stalls = 0;
             build_beats(int'(height), int'(Win_div_Tin), int'(Wout_div_Tout), base_addr);
             if (q.size() == 0) begin m_phase = 2; m_done = 1; m_fin_busy = 1; end
             else m_phase = 1;
           end
        1: if (dat_rdy) begin
             q.delete(0);
             if (q.size() == 0) begin m_phase = 2; m_done = 1; m_fin_busy = 0; end
           end else if (m_stalls != 32'hFFFF_FFFF) m_stalls = m_stalls + 1;
        default: m_phase = 0;
      endcase
    end
  end

  // Capture of observed traffic for the literal checks
  logic [15:0] cap_addr[$];
  bit          cap_first[$], cap_last[$];
  int          done_cyc, busy_cnt, vld_cnt;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("dat_vld", 32'(dat_vld), 32'(m_phase == 1));
      chk("busy", 32'(busy), 32'((m_phase == 1) || (m_phase == 2 && m_fin_busy)));
      chk("done", 32'(done), 32'(m_done));
      chk("stall_cycles", stall_cycles, STALL_ON ? m_stalls : 32'd0);
      if (m_phase == 1 && q.size() > 0) begin
        chk("dat_addr", 32'(dat_addr), 32'(q[0].addr));
        chk("dat_first", 32'(dat_first), 32'(q[0].first));
        chk("dat_last", 32'(dat_last), 32'(q[0].last));
      end
      if (!rst && dat_vld && dat_rdy) begin
        cap_addr.push_back(dat_addr);
        cap_first.push_back(dat_first);
        cap_last.push_back(dat_last);
      end
      if (done && done_cyc < 0) done_cyc = cyc;
      if (busy) busy_cnt++;
      if (dat_vld) vld_cnt++;
    end
  end

  int t0;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic clear_cap();
    cap_addr.delete(); cap_first.delete(); cap_last.delete();
    done_cyc = -1; busy_cnt = 0; vld_cnt = 0;
  endtask

  task automatic start_pass(input int h, input int wi, input int wo, input logic [15:0] b);
    clear_cap();
    start = 1; height = 10'(h); Win_div_Tin = 8'(wi); Wout_div_Tout = 8'(wo); base_addr = b;
    t0 = cyc;
  endtask

  // k counts cycles after the start cycle; dat_rdy low for k in [lo,hi]
  task automatic run_pass(input int lo, input int hi, input int pulse_at, input int rst_at);
    bit fin = 0;
    for (int k = 1; k <= 200 && !fin; k++) begin
      step();
      dat_rdy = !(k >= lo && k <= hi);
      start   = (k == pulse_at);
      if (k == pulse_at) begin
        height = 10'd1; Win_div_Tin = 8'd1; Wout_div_Tout = 8'd1; base_addr = 16'hABCD;
      end
      rst = (k == rst_at);
      if (k > 1 && m_phase == 0 && !busy && !start && !rst) fin = 1;
    end
    if (!fin) chk("pass_timeout", 32'd1, 32'd0);
  endtask

  task automatic chk_addrs12(input string nm);
    logic [15:0] exp12 [12] = '{16'h100, 16'h101, 16'h102, 16'h103, 16'h104, 16'h105,
                                16'h100, 16'h101, 16'h102, 16'h103, 16'h104, 16'h105};
    chk({nm, "_beats"}, 32'(cap_addr.size()), 32'd12);
    if (cap_addr.size() == 12)
      for (int i = 0; i < 12; i++) chk({nm, "_addr"}, 32'(cap_addr[i]), 32'(exp12[i]));
  endtask

  initial begin
    rst = 1; start = 0; dat_rdy = 1; height = 0; Win_div_Tin = 0; Wout_div_Tout = 0; base_addr = 0;
    done_cyc = -1;
    step(); chk_en = 1;
    step(); step();
    rst = 0;
    step();
    chk("rst_vld", 32'(dat_vld), 32'd0);
    chk("rst_addr", 32'(dat_addr), 32'd0);
    chk("rst_first", 32'(dat_first), 32'd0);
    chk("rst_last", 32'(dat_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_stall", stall_cycles, 32'd0);

    // Basic 3x2x2 pass at full throughput
    start_pass(3, 2, 2, 16'h100);
    run_pass(0, -1, -1, -1);
    chk_addrs12("t1");
    if (cap_addr.size() == 12) begin
      chk("t1_first1", 32'(cap_first[0]), 32'd1);
      chk("t1_first2", 32'(cap_first[1]), 32'd0);
      chk("t1_first7", 32'(cap_first[6]), 32'd1);
      chk("t1_last11", 32'(cap_last[10]), 32'd0);
      chk("t1_last12", 32'(cap_last[11]), 32'd1);
    end
    chk("t1_done_cyc", 32'(done_cyc - t0), 32'd13);
    chk("t1_busy_cnt", 32'(busy_cnt), 32'd12);

    // Backpressure on cycles T+2..T+4
    step();
    start_pass(3, 2, 2, 16'h100);
    run_pass(2, 4, -1, -1);
    chk_addrs12("t2");
    chk("t2_done_cyc", 32'(done_cyc - t0), 32'd16);
    chk("t2_stall", stall_cycles, STALL_ON ? 32'd3 : 32'd0);
    chk("t2_vld_cnt", 32'(vld_cnt), 32'd15);

    // Zero height
    step();
    start_pass(0, 4, 4, 16'h200);
    run_pass(0, -1, -1, -1);
    chk("t3_vld_cnt", 32'(vld_cnt), 32'd0);
    chk("t3_busy_cnt", 32'(busy_cnt), 32'd1);
    chk("t3_done_cyc", 32'(done_cyc - t0), 32'd1);

    // Address wrap
    step();
    start_pass(4, 1, 1, 16'hFFFE);
    run_pass(0, -1, -1, -1);
    chk("t4_beats", 32'(cap_addr.size()), 32'd4);
    if (cap_addr.size() == 4) begin
      chk("t4_a0", 32'(cap_addr[0]), 32'hFFFE);
      chk("t4_a1", 32'(cap_addr[1]), 32'hFFFF);
      chk("t4_a2", 32'(cap_addr[2]), 32'h0000);
      chk("t4_a3", 32'(cap_addr[3]), 32'h0001);
      chk("t4_last", 32'(cap_last[3]), 32'd1);
    end
    chk("t4_done_cyc", 32'(done_cyc - t0), 32'd5);

    // start re-pulsed mid-pass with other config
    step();
    start_pass(3, 2, 2, 16'h100);
    run_pass(0, -1, 5, -1);
    chk_addrs12("t5");
    chk("t5_done_cyc", 32'(done_cyc - t0), 32'd13);

    // rst at T+6, restart at T+9
    step();
    start_pass(3, 2, 2, 16'h100);
    run_pass(0, -1, -1, 6);
    chk("t6_rst_cyc", 32'(cyc - t0), 32'd7);
    chk("t6_vld", 32'(dat_vld), 32'd0);
    chk("t6_addr", 32'(dat_addr), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_no_done", 32'(done_cyc), 32'hFFFF_FFFF);
    step(); step();
    start_pass(3, 2, 2, 16'h100);
    run_pass(0, -1, -1, -1);
    chk_addrs12("t6r");
    chk("t6r_done_cyc", 32'(done_cyc - t0), 32'd13);

    step(); step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
